// File: rtl/uart_frame_rx_ctrl.sv
// Frame-level controller behind the UART byte receiver.
// Hunts SYNC, captures LEN/payload/CSUM, holds good frames.
module uart_frame_rx_ctrl #(
  parameter logic [7:0]  SYNC_BYTE = 8'hA5,
  parameter int          MAX_LEN   = 16,
  parameter int unsigned TIMEOUT   = 100000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  input  logic       frame_ack,
  input  logic [7:0] rd_addr,
  output logic [7:0] rd_data,
  output logic       frame_valid,
  output logic [7:0] frame_len,
  output logic       frame_err,
  output logic [1:0] err_code,
  output logic       busy
);

  localparam int AW =
    (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam int DEPTH = 1 << AW;
  localparam logic [8:0] MAXL = 9'(MAX_LEN);

  localparam logic [1:0] E_OVR = 2'd0;
  localparam logic [1:0] E_LEN = 2'd1;
  localparam logic [1:0] E_SUM = 2'd2;
  localparam logic [1:0] E_TMO = 2'd3;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LEN,
    ST_PAYLOAD,
    ST_CSUM,
    ST_HOLD
  } state_t;

  state_t      state;
  logic [7:0]  len_q;
  logic [7:0]  sum;
  logic [7:0]  idx;
  logic [31:0] gap;

  logic [7:0]  mem [DEPTH];

  logic        in_frame;
  logic        is_sync;
  logic        len_bad;
  logic        last_byte;
  logic        gap_hit;
  logic        sum_ok;
  logic        mem_we;
  logic        rd_ok;
  logic [7:0]  sum_next;

  // Decode of the current byte against the frame state.
  always_comb begin
    in_frame  = (state == ST_LEN)
             || (state == ST_PAYLOAD)
             || (state == ST_CSUM);
    is_sync   = (rx_data == SYNC_BYTE);
    len_bad   = (rx_data == 8'd0)
             || ({1'b0, rx_data} > MAXL);
    last_byte = (idx == len_q - 8'd1);
    gap_hit   = (gap == TIMEOUT);
    sum_ok    = (rx_data == sum);
    sum_next  = sum + rx_data;
    mem_we    = !rst && rx_valid
             && (state == ST_PAYLOAD);
    rd_ok     = ({1'b0, rd_addr} < MAXL);
  end

  // Frame sequencer with registered status outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      len_q       <= 8'd0;
      sum         <= 8'd0;
      idx         <= 8'd0;
      gap         <= 32'd0;
      frame_valid <= 1'b0;
      frame_len   <= 8'd0;
      frame_err   <= 1'b0;
      err_code    <= 2'd0;
      busy        <= 1'b0;
    end else begin
      frame_err <= 1'b0;

      if (in_frame && !rx_valid)
        gap <= gap + 32'd1;
      else
        gap <= 32'd0;

      unique case (state)
        ST_IDLE: begin
          if (rx_valid && is_sync) begin
            state <= ST_LEN;
            busy  <= 1'b1;
          end
        end

        ST_LEN: begin
          if (rx_valid) begin
            if (len_bad) begin
              state     <= ST_IDLE;
              busy      <= 1'b0;
              frame_err <= 1'b1;
              err_code  <= E_LEN;
            end else begin
              len_q <= rx_data;
              sum   <= rx_data;
              idx   <= 8'd0;
              state <= ST_PAYLOAD;
            end
          end
        end

        ST_PAYLOAD: begin
          if (rx_valid) begin
            sum <= sum_next;
            idx <= idx + 8'd1;
            if (last_byte)
              state <= ST_CSUM;
          end
        end

        ST_CSUM: begin
          if (rx_valid) begin
            busy <= 1'b0;
            if (sum_ok) begin
              frame_len   <= len_q;
              frame_valid <= 1'b1;
              state       <= ST_HOLD;
            end else begin
              state     <= ST_IDLE;
              frame_err <= 1'b1;
              err_code  <= E_SUM;
            end
          end
        end

        ST_HOLD: begin
          if (rx_valid) begin
            frame_err <= 1'b1;
            err_code  <= E_OVR;
          end
          if (frame_ack) begin
            frame_valid <= 1'b0;
            state       <= ST_IDLE;
          end
        end

        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
      endcase

      // A byte in the same cycle as the limit wins.
      if (in_frame && !rx_valid && gap_hit) begin
        state     <= ST_IDLE;
        busy      <= 1'b0;
        frame_err <= 1'b1;
        err_code  <= E_TMO;
      end
    end
  end

  // Payload buffer write; contents are never reset.
  always_ff @(posedge clk) begin
    if (mem_we)
      mem[idx[AW-1:0]] <= rx_data;
  end

  // Registered payload read, zero outside the buffer.
  always_ff @(posedge clk) begin
    if (rst)
      rd_data <= 8'd0;
    else if (rd_ok)
      rd_data <= mem[rd_addr[AW-1:0]];
    else
      rd_data <= 8'd0;
  end

endmodule

// File: tb/tb_uart_frame_rx_ctrl.sv
// Self-checking bench for uart_frame_rx_ctrl.
// Scoreboard queues hold expected errors and frame lengths.
module tb_uart_frame_rx_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       frame_ack;
  logic [7:0] rd_addr;
  logic [7:0] rd_data;
  logic       frame_valid;
  logic [7:0] frame_len;
  logic       frame_err;
  logic [1:0] err_code;
  logic       busy;

  int vectors = 0;
  int miscompares = 0;

  logic [1:0] exp_err [$];
  logic [7:0] exp_len [$];
  logic [7:0] txq [$];
  logic [7:0] pay [16];
  bit         prev_fv = 1'b0;

  always #5 clk = ~clk;

  uart_frame_rx_ctrl #(
    .SYNC_BYTE(8'hA5),
    .MAX_LEN  (16),
    .TIMEOUT  (50)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .frame_ack  (frame_ack),
    .rd_addr    (rd_addr),
    .rd_data    (rd_data),
    .frame_valid(frame_valid),
    .frame_len  (frame_len),
    .frame_err  (frame_err),
    .err_code   (err_code),
    .busy       (busy)
  );

  // Scoreboard monitor: pops on each error pulse / frame rise.
  always @(negedge clk) begin
    if (rst !== 1'b0) begin
      prev_fv = 1'b0;
    end else begin
      if (frame_err === 1'b1) begin
        vectors++;
        if (exp_err.size() == 0) begin
          miscompares++;
          $display("FAIL sb_err unexpected code=%0d", err_code);
        end else begin
          logic [1:0] e;
          e = exp_err.pop_front();
          if (err_code !== e) begin
            miscompares++;
            $display("FAIL sb_err code got=%0d exp=%0d",
                     err_code, e);
          end
        end
      end
      if (frame_valid === 1'b1 && !prev_fv) begin
        vectors++;
        if (exp_len.size() == 0) begin
          miscompares++;
          $display("FAIL sb_frame unexpected len=%0d",
                   frame_len);
        end else begin
          logic [7:0] l;
          l = exp_len.pop_front();
          if (frame_len !== l) begin
            miscompares++;
            $display("FAIL sb_frame len got=%0d exp=%0d",
                     frame_len, l);
          end
        end
      end
      prev_fv = (frame_valid === 1'b1);
    end
  end

  // Drive txq back-to-back, one byte per cycle, from a negedge.
  task automatic send_q();
    foreach (txq[i]) begin
      rx_data  = txq[i];
      rx_valid = 1'b1;
      @(negedge clk);
    end
    rx_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic ack();
    frame_ack = 1'b1;
    @(negedge clk);
    frame_ack = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    rx_valid = 1'b0;
    rx_data = 8'h00;
    frame_ack = 1'b0;
    rd_addr = 8'h00;
    idle(3);
    vectors++;
    if ({frame_valid, frame_len, frame_err, err_code,
         rd_data, busy} !== 21'd0) begin
      miscompares++;
      $display("FAIL reset got fv=%b len=%h err=%b code=%0d rd=%h busy=%b exp all 0",
               frame_valid, frame_len, frame_err,
               err_code, rd_data, busy);
    end
    rst = 1'b0;
    idle(1);
  endtask

  task automatic test_good_frame();
    exp_len.push_back(8'd3);
    txq = '{8'hA5, 8'h03, 8'h11, 8'h22, 8'h33, 8'h69};
    send_q();
    vectors++;
    if (frame_valid !== 1'b1 || frame_len !== 8'd3
        || frame_err !== 1'b0 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL good_frame fv=%b len=%0d err=%b busy=%b exp 1/3/0/0",
               frame_valid, frame_len, frame_err, busy);
    end
    txq = '{8'h11, 8'h22, 8'h33};
    foreach (txq[i]) begin
      rd_addr = 8'(i);
      @(negedge clk);
      vectors++;
      if (rd_data !== txq[i]) begin
        miscompares++;
        $display("FAIL good_read addr=%0d got=%h exp=%h",
                 i, rd_data, txq[i]);
      end
    end
    rd_addr = 8'd200;
    @(negedge clk);
    vectors++;
    if (rd_data !== 8'h00) begin
      miscompares++;
      $display("FAIL read_oob got=%h exp=00", rd_data);
    end
    ack();
    vectors++;
    if (frame_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL ack_release fv=%b exp=0", frame_valid);
    end
  endtask

  task automatic test_bad_checksum();
    exp_err.push_back(2'd2);
    txq = '{8'hA5, 8'h02, 8'h10, 8'h20, 8'h00};
    send_q();
    vectors++;
    if (frame_err !== 1'b1 || err_code !== 2'd2
        || frame_valid !== 1'b0 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL bad_csum err=%b code=%0d fv=%b busy=%b exp 1/2/0/0",
               frame_err, err_code, frame_valid, busy);
    end
    idle(1);
    vectors++;
    if (frame_err !== 1'b0 || err_code !== 2'd2) begin
      miscompares++;
      $display("FAIL err_pulse err=%b code=%0d exp 0/2",
               frame_err, err_code);
    end
    exp_len.push_back(8'd1);
    txq = '{8'hA5, 8'h01, 8'h7F, 8'h80};
    send_q();
    vectors++;
    if (frame_valid !== 1'b1 || frame_len !== 8'd1) begin
      miscompares++;
      $display("FAIL after_csum fv=%b len=%0d exp 1/1",
               frame_valid, frame_len);
    end
    ack();
  endtask

  task automatic test_bad_length();
    txq = '{8'h00, 8'hFF};
    send_q();
    vectors++;
    if (frame_err !== 1'b0 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL garbage err=%b busy=%b exp 0/0",
               frame_err, busy);
    end
    exp_err.push_back(2'd1);
    txq = '{8'hA5, 8'h00};
    send_q();
    vectors++;
    if (frame_err !== 1'b1 || err_code !== 2'd1) begin
      miscompares++;
      $display("FAIL len_zero err=%b code=%0d exp 1/1",
               frame_err, err_code);
    end
    idle(1);
    exp_err.push_back(2'd1);
    txq = '{8'hA5, 8'h11};
    send_q();
    vectors++;
    if (frame_err !== 1'b1 || err_code !== 2'd1
        || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL len_big err=%b code=%0d busy=%b exp 1/1/0",
               frame_err, err_code, busy);
    end
    idle(1);
  endtask

  task automatic test_timeout();
    exp_err.push_back(2'd3);
    txq = '{8'hA5, 8'h02, 8'h10};
    send_q();
    idle(50);
    vectors++;
    if (frame_err !== 1'b0 || busy !== 1'b1) begin
      miscompares++;
      $display("FAIL tmo_early err=%b busy=%b exp 0/1",
               frame_err, busy);
    end
    idle(1);
    vectors++;
    if (frame_err !== 1'b1 || err_code !== 2'd3
        || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL tmo err=%b code=%0d busy=%b exp 1/3/0",
               frame_err, err_code, busy);
    end
    idle(1);
    exp_len.push_back(8'd2);
    txq = '{8'hA5, 8'h02, 8'h10};
    send_q();
    idle(50);
    txq = '{8'h20, 8'h32};
    send_q();
    vectors++;
    if (frame_valid !== 1'b1 || frame_len !== 8'd2
        || frame_err !== 1'b0) begin
      miscompares++;
      $display("FAIL tmo_edge fv=%b len=%0d err=%b exp 1/2/0",
               frame_valid, frame_len, frame_err);
    end
    ack();
  endtask

  task automatic test_overrun();
    exp_len.push_back(8'd3);
    txq = '{8'hA5, 8'h03, 8'h01, 8'h02, 8'h03, 8'h09};
    send_q();
    exp_err.push_back(2'd0);
    txq = '{8'h55};
    send_q();
    vectors++;
    if (frame_err !== 1'b1 || err_code !== 2'd0
        || frame_valid !== 1'b1 || frame_len !== 8'd3) begin
      miscompares++;
      $display("FAIL overrun err=%b code=%0d fv=%b len=%0d exp 1/0/1/3",
               frame_err, err_code, frame_valid, frame_len);
    end
    txq = '{8'h01, 8'h02, 8'h03};
    foreach (txq[i]) begin
      rd_addr = 8'(i);
      @(negedge clk);
      vectors++;
      if (rd_data !== txq[i]) begin
        miscompares++;
        $display("FAIL hold_buf addr=%0d got=%h exp=%h",
                 i, rd_data, txq[i]);
      end
    end
    exp_err.push_back(2'd0);
    rx_data = 8'h66;
    rx_valid = 1'b1;
    frame_ack = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
    frame_ack = 1'b0;
    vectors++;
    if (frame_err !== 1'b1 || err_code !== 2'd0
        || frame_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL ack_ovr err=%b code=%0d fv=%b exp 1/0/0",
               frame_err, err_code, frame_valid);
    end
    idle(1);
  endtask

  task automatic test_back_to_back();
    logic [7:0] s;
    s = 8'd16;
    for (int i = 0; i < 16; i++) begin
      pay[i] = 8'(i * 17 + 3);
    end
    pay[5] = 8'hA5;
    txq = '{8'hA5, 8'h10};
    for (int i = 0; i < 16; i++) begin
      txq.push_back(pay[i]);
      s = s + pay[i];
    end
    txq.push_back(s);
    exp_len.push_back(8'd16);
    send_q();
    vectors++;
    if (frame_valid !== 1'b1 || frame_len !== 8'd16) begin
      miscompares++;
      $display("FAIL max_len fv=%b len=%0d exp 1/16",
               frame_valid, frame_len);
    end
    for (int i = 0; i <= 16; i++) begin
      rd_addr = 8'(i);
      @(negedge clk);
      vectors++;
      if (rd_data !== ((i < 16) ? pay[i] : 8'h00)) begin
        miscompares++;
        $display("FAIL max_read addr=%0d got=%h exp=%h",
                 i, rd_data,
                 (i < 16) ? pay[i] : 8'h00);
      end
    end
    ack();
  endtask

  task automatic test_reset_midframe();
    txq = '{8'hA5, 8'h04, 8'h01, 8'h02};
    send_q();
    vectors++;
    if (busy !== 1'b1) begin
      miscompares++;
      $display("FAIL mid_busy got=%b exp=1", busy);
    end
    rst = 1'b1;
    @(negedge clk);
    vectors++;
    if ({frame_valid, frame_len, frame_err, err_code,
         rd_data, busy} !== 21'd0) begin
      miscompares++;
      $display("FAIL mid_reset fv=%b len=%h err=%b code=%0d rd=%h busy=%b exp all 0",
               frame_valid, frame_len, frame_err,
               err_code, rd_data, busy);
    end
    rst = 1'b0;
    exp_len.push_back(8'd1);
    txq = '{8'hA5, 8'h01, 8'hAA, 8'hAB};
    send_q();
    vectors++;
    if (frame_valid !== 1'b1 || frame_len !== 8'd1) begin
      miscompares++;
      $display("FAIL post_reset fv=%b len=%0d exp 1/1",
               frame_valid, frame_len);
    end
    ack();
  endtask

  task automatic test_drain();
    idle(2);
    vectors++;
    if (exp_err.size() != 0 || exp_len.size() != 0) begin
      miscompares++;
      $display("FAIL sb_drain errs=%0d frames=%0d exp 0/0",
               exp_err.size(), exp_len.size());
    end
  endtask

  initial begin
    test_reset();
    test_good_frame();
    test_bad_checksum();
    test_bad_length();
    test_timeout();
    test_overrun();
    test_back_to_back();
    test_reset_midframe();
    test_drain();
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/uart_frame_rx_ctrl.md
# uart_frame_rx_ctrl

Frame-level controller that sits behind the byte-level UART receiver and sequences its output stream into validated command frames. It hunts for a sync byte, captures a length byte, payload bytes and a checksum byte into an internal buffer, enforces an inter-byte timeout, and hands each good frame to the command decoder through a valid/ack handshake. While a frame is held, the payload buffer is locked. Any bytes that arrive during that time are dropped and reported.

## Interface
- SYNC_BYTE, 8'hA5, frame start marker
- MAX_LEN, 16, maximum payload bytes (1..255); sets buffer depth
- TIMEOUT, 100000, maximum clk cycles between consecutive bytes inside a frame
- clk  input  1  clock
- rst  input  1  reset, synchronous, active-high
- rx_data  input  8  byte from the UART receiver
- rx_valid  input  1  one-cycle strobe: rx_data valid this cycle
- frame_ack  input  1  consumer releases the held frame
- rd_addr  input  8  payload read address
- rd_data  output  8  payload byte at rd_addr, registered
- frame_valid  output  1  level, high while a good frame is held
- frame_len  output  8  payload length of the held frame
- frame_err  output  1  one-cycle error pulse
- err_code  output  2  valid with frame_err: 0 overrun, 1 bad length, 2 bad checksum, 3 timeout
- busy  output  1  high in LEN, PAYLOAD and CSUM states

## Operation
- Frame format: SYNC_BYTE, LEN (1..MAX_LEN), LEN payload bytes, CSUM.
- CSUM must equal the 8-bit modulo-256 sum of LEN and all payload bytes.
- States: IDLE, LEN, PAYLOAD, CSUM, HOLD. Reset state is IDLE.
- IDLE: a byte equal to SYNC_BYTE moves to LEN. Other bytes are silently ignored, with no error.
- LEN: if the byte is 0 or greater than MAX_LEN, emit err 1 and return to IDLE.
  - Otherwise latch it as the length, set sum = byte, clear the index and move to PAYLOAD.
- PAYLOAD: each byte is written to buf[index], added to sum (mod 256), and index is incremented.
  - After the byte at index LEN-1 is written, move to CSUM.
- CSUM: if the byte equals sum, update frame_len and move to HOLD. Otherwise emit err 2 and return to IDLE.
- HOLD: frame_valid = 1. frame_ack moves to IDLE.
  - Every rx_valid in HOLD is dropped and emits err 0, including a byte that arrives in the same cycle as frame_ack.
- Timeout: in LEN, PAYLOAD and CSUM, a gap counter clears on each rx_valid and on state entry, and increments otherwise.
  - When the counter reaches TIMEOUT, emit err 3 and return to IDLE.
  - If rx_valid arrives in the same cycle the counter reaches TIMEOUT, the byte wins: it is processed and the counter clears.
- frame_ack outside HOLD is ignored.
- A failed frame never changes frame_len, but its payload writes may overwrite buf.
  - No frame is valid in that case, so buf contents are don't-care.
- Read port: rd_data <= buf[rd_addr] when rd_addr < MAX_LEN, else 8'h00. The read is active in every state.
- buf is not reset. Widths: sum 8-bit wrap, index 8-bit, gap counter 32-bit.

## Timing
- Reset values: frame_valid 0, frame_len 0, frame_err 0, err_code 0, rd_data 0, busy 0, state IDLE, sum 0, index 0, gap counter 0.
- rst has priority over all inputs. Reset mid-frame or in HOLD returns to IDLE next cycle and discards the frame.
- All outputs are registered.
- frame_valid rises in the cycle after the rx_valid cycle of a correct CSUM byte.
- frame_valid falls in the cycle after frame_ack is sampled in HOLD.
- frame_err and err_code are asserted in the cycle after the offending rx_valid, or the cycle after the timeout count is reached. frame_err lasts exactly one cycle.
- err_code holds its last value when frame_err is low.
- rd_data latency is 1 cycle from rd_addr.
- rx_valid may arrive on back-to-back cycles. Every byte is accepted with no stall, since there is no backpressure.
- A SYNC_BYTE value arriving inside a frame is treated as data, not as a resync.

## Test plan
- Good frame: A5 03 11 22 33 69 -> frame_valid=1 one cycle after the 69 strobe, frame_len=3.
  - Read addresses 0..2 -> 11, 22, 33 with 1-cycle latency. No frame_err.
- Bad checksum: A5 02 10 20 00 -> frame_err with err_code 2 one cycle after the 00 strobe, frame_valid stays 0, state returns to IDLE.
  - A following good frame (A5 01 7F 80) -> frame_valid=1, frame_len=1.
- Bad length: A5 00, and separately A5 11 with MAX_LEN=16 -> err_code 1 each time. Garbage bytes 00 FF before A5 -> no error.
- Timeout with TIMEOUT=50: A5 02 10, then idle for 50 cycles -> err_code 3 pulse, busy falls.
  - Repeat with the next byte arriving exactly at count 50 -> no error, byte accepted.
- Overrun/handshake: hold a good frame and send byte 55 without ack -> err_code 0, frame_valid stays 1 and the buffer is unchanged.
  - frame_ack coincident with rx_valid -> err 0, and frame_valid falls the next cycle.
- Reset mid-frame: A5 04 01 02, then pulse rst -> all outputs return to reset values.
  - A following good frame A5 01 AA AB -> frame_valid=1, frame_len=1.
